// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential divider.
//   - XLEN_DEFAULT : default operand/result width
//   - div_state_t  : FSM state encoding (IDLE / BUSY / DONE)
//   - cnt_width()  : width of the iteration counter for a given XLEN
package div_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_BUSY = 2'd1;
    localparam div_state_t ST_DONE = 2'd2;

    // Counter runs 0..xlen-1.
    function automatic int unsigned cnt_width(input int unsigned xlen);
        return (xlen < 2) ? 1 : $clog2(xlen);
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(XLEN_DEFAULT);

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring radix-2 division iteration.
// Ports:
//   rem_i     - current partial remainder (always < divisor)
//   quo_i     - dividend/quotient shift register; MSB is the next dividend bit
//   divisor_i - unsigned divisor magnitude
//   rem_o     - updated partial remainder
//   quo_o     - shift register with the new quotient bit in the LSB
module div_step
    import div_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // The shifted remainder can reach 2*divisor-1, hence the extra bit.
    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor_i};

    // trial MSB set means the subtraction went negative: restore.
    assign rem_o = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed/unsigned integer divider (DIV/DIVU/REM/REMU).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start               - level request, sampled only in IDLE
//   signed_div          - 1 = signed operation, 0 = unsigned
//   dividend, divisor   - operands, sampled at acceptance
//   quotient, remainder - registered results, held until the next completion
//   status              - high while iterating (BUSY)
//   finished            - one-cycle pulse in DONE; results valid that cycle
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            signed_div,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            status,
    output logic            finished
);

    localparam int unsigned CntW = cnt_width(XLEN);

    div_state_t      state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [XLEN-1:0] quo_q, quo_d;      // dividend magnitude shifting into quotient
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] remainder_q, remainder_d;

    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] abs_dividend;
    logic [XLEN-1:0] abs_divisor;
    logic            div_by_zero;
    logic            overflow;

    div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Magnitudes: the most negative value maps to itself, which is the correct
    // unsigned magnitude.
    assign abs_dividend = (signed_div && dividend[XLEN-1]) ? -dividend : dividend;
    assign abs_divisor  = (signed_div && divisor[XLEN-1])  ? -divisor  : divisor;
    assign div_by_zero  = (divisor == '0);
    assign overflow     = signed_div && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (&divisor);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d = '0;
                    if (div_by_zero) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        state_d     = ST_DONE;
                    end else if (overflow) begin
                        quotient_d  = dividend;
                        remainder_d = '0;
                        state_d     = ST_DONE;
                    end else begin
                        quo_d     = abs_dividend;
                        dvs_d     = abs_divisor;
                        rem_d     = '0;
                        neg_quo_d = signed_div && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        neg_rem_d = signed_div && dividend[XLEN-1];
                        state_d   = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                quo_d   = step_quo;
                rem_d   = step_rem;
                count_d = count_q + CntW'(1);
                if (count_q == CntW'(XLEN - 1)) begin
                    // Negating a zero remainder leaves it zero.
                    quotient_d  = neg_quo_q ? -step_quo : step_quo;
                    remainder_d = neg_rem_q ? -step_rem : step_rem;
                    count_d     = '0;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign status    = (state_q == ST_BUSY);
    assign finished  = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (XLEN = 32).
// Directed vectors from a table, hand-written multi-cycle sequences, and
// random operations checked against an arithmetic reference model.
module tb_seq_divider;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            reset;
    logic            start;
    logic            signed_div;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            status;
    logic            finished;

    int checks;
    int errors;

    seq_divider #(
        .XLEN (XLEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .status     (status),
        .finished   (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic plus the architectural special cases.
    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb;
        if (b == 32'd0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            lat = 1;
        end else if (sgn) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            q   = 32'(sa / sb);
            r   = 32'(sa % sb);
            lat = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 1 : 33;
        end else begin
            q   = a / b;
            r   = a % b;
            lat = 33;
        end
    endtask

    // Issues one operation from IDLE; scrambles all inputs while it runs.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int elat,
                          input string nm);
        int cyc;
        int busy;
        int overlap;
        bit done;
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        cyc = 0; busy = 0; overlap = 0; done = 1'b0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (status && finished) overlap++;
            if (status) busy++;
            if (finished) begin
                done = 1'b1;
            end else begin
                start      = 1'($urandom_range(0, 1));
                signed_div = 1'($urandom_range(0, 1));
                dividend   = $urandom;
                divisor    = $urandom;
            end
        end
        start = 1'b0;
        chk({nm, " quotient"}, quotient, eq);
        chk({nm, " remainder"}, remainder, er);
        chk({nm, " latency"}, 32'(cyc), 32'(elat));
        chk({nm, " busy cycles"}, 32'(busy), (elat == 1) ? 32'd0 : 32'd32);
        chk({nm, " status&finished"}, 32'(overlap), 32'd0);
        @(posedge clk); #1;
        chk({nm, " finished width"}, {31'd0, finished}, 32'd0);
    endtask

    logic [31:0] mq, mr;
    int          mlat;
    int          cyc;
    int          fin_cnt;
    logic        rs;
    logic [31:0] ra, rb;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vecs[3] = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1};
        vecs[4] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1};
        vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
        vecs[7] = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFC,  32'd2,          32'd0,          33};
        vecs[8] = '{1'b1, 32'hFFFF_FFF7,  32'hFFFF_FFFC,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[9] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};

        reset = 1'b1; start = 1'b0; signed_div = 1'b0; dividend = '0; divisor = '0;
        #1;
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset status", {31'd0, status}, 32'd0);
        chk("reset finished", {31'd0, finished}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Results hold while idle with garbage on the inputs.
        for (int i = 0; i < 5; i++) begin
            dividend = $urandom; divisor = $urandom; signed_div = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk("hold quotient", quotient, vecs[9].q);
        chk("hold remainder", remainder, vecs[9].r);

        // Back-to-back: start stays high through DONE, new operands for the next IDLE.
        signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        cyc = 0;
        while (!finished && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b first latency", 32'(cyc), 32'd33);
        chk("b2b first quotient", quotient, 32'd14);
        chk("b2b first remainder", remainder, 32'd2);
        dividend = 32'd50; divisor = 32'd5;
        cyc = 0; fin_cnt = 0;
        @(posedge clk); #1;
        cyc++;
        chk("b2b idle gap finished", {31'd0, finished}, 32'd0);
        while (!finished && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (finished) fin_cnt++;
        start = 1'b0;
        chk("b2b second latency", 32'(cyc), 32'd34);
        chk("b2b second pulses", 32'(fin_cnt), 32'd1);
        chk("b2b second quotient", quotient, 32'd10);
        chk("b2b second remainder", remainder, 32'd0);
        @(posedge clk); #1;
        chk("b2b finished drop", {31'd0, finished}, 32'd0);

        // Reset in the 10th BUSY cycle discards the operation.
        signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("rst pre status", {31'd0, status}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst quotient", quotient, 32'd0);
        chk("rst remainder", remainder, 32'd0);
        chk("rst status", {31'd0, status}, 32'd0);
        chk("rst finished", {31'd0, finished}, 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        fin_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (finished) fin_cnt++;
        end
        chk("rst no finished", 32'(fin_cnt), 32'd0);
        run_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33, "post-reset 9/4");

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin rs = 1'b1; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            model(rs, ra, rb, mq, mr, mlat);
            run_op(rs, ra, rb, mq, mr, mlat, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, level request from the execute stage, held high while a divide instruction sits in EX.
REQ-005 SHALL have port signed_div, input, 1, 1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-006 SHALL have ports dividend and divisor, input, XLEN each, operands sampled only at acceptance.
REQ-007 SHALL have ports quotient and remainder, output, XLEN each, registered results.
REQ-008 SHALL have port status, output, 1, high only while in BUSY.
REQ-009 SHALL have port finished, output, 1, one-cycle pulse; quotient/remainder valid in that cycle.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 IDLE with start=1 SHALL accept: latch |dividend|, |divisor| (abs only when signed_div=1), result-sign flags, iteration count=0.
REQ-012 On acceptance with divisor=0, SHALL go directly to DONE with quotient=all ones and remainder=dividend, for both signed and unsigned.
REQ-013 On acceptance with signed_div=1, dividend=0x80000000 (XLEN-wide min) and divisor=all ones, SHALL go directly to DONE with quotient=dividend, remainder=0.
REQ-014 Otherwise SHALL go to BUSY; each BUSY cycle performs one restoring radix-2 step, using an XLEN+1-bit partial remainder for the trial subtraction.
REQ-015 After exactly XLEN BUSY cycles, SHALL register results and go to DONE.
REQ-016 Signed results: quotient negated iff the operand signs differ; remainder takes the sign of the dividend; a zero remainder stays zero.
REQ-017 Latency: the start cycle in IDLE, then XLEN BUSY cycles, then DONE, so finished is asserted 33 cycles after start is first seen (XLEN=32); special cases assert finished 1 cycle after.
REQ-018 DONE SHALL assert finished=1, status=0, and return to IDLE unconditionally next cycle, even if start is still high.
REQ-019 A start seen in IDLE in the cycle after DONE SHALL be accepted as a new operation, allowing back-to-back divides.
REQ-020 start, signed_div, dividend and divisor SHALL be ignored in BUSY and DONE; start dropping mid-operation SHALL not abort it.
REQ-021 quotient/remainder SHALL hold their last completed values until the next DONE.
REQ-022 finished SHALL never be high while status is high; the execute stall term status || (start && ~finished) SHALL therefore release exactly in the DONE cycle.

Reset
REQ-023 reset=1 SHALL asynchronously force state=IDLE and count=0, and force quotient, remainder, status and finished to 0.
REQ-024 Reset mid-BUSY SHALL discard the operation; no finished pulse follows.

Structure
REQ-025 The FSM state enum, XLEN default and iteration-count width SHALL live in shared package div_pkg.
REQ-026 One combinational sub-module div_step SHALL implement a single restoring iteration: partial remainder and quotient in, updated pair out.
REQ-027 Sign fix-up and special-case detection SHALL stay in seq_divider; no other sub-modules.

Verification
REQ-028 Unsigned 100/7, start held -> status high 32 cycles, finished 33 cycles after start, q=14, r=2.
REQ-029 Signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1.
REQ-030 Signed and unsigned 5/0 -> finished 1 cycle after start, q=0xFFFFFFFF, r=5, status never high.
REQ-031 Signed 0x80000000/0xFFFFFFFF -> 1-cycle q=0x80000000, r=0; unsigned same operands -> full latency, q=0, r=0x80000000.
REQ-032 Back-to-back: start high through DONE, new operands 50/5 in next IDLE -> second op accepted, q=10, r=0; exactly one finished pulse per op.
REQ-033 Reset asserted at BUSY cycle 10 -> outputs 0 immediately, no finished; then 9/4 completes with q=2, r=1.
